// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (signed/unsigned) with a one-cycle result pulse.
// Optional DIV_EARLY_OUT_EN: skip the iteration when the quotient is trivially known.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               div_signed,
   input  logic               div_cancel,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   output logic               m_axis_dout_tvalid,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
   logic             r_nq, r_nr;
   logic             w_ready, w_accept, w_sa, w_sb;
   logic [WIDTH-1:0] w_ma, w_mb, w_rem, w_quo;
   logic [WIDTH:0]   w_trial;

   function automatic logic [2*WIDTH-1:0] fixup(input logic nq, input logic nr,
                                                 input logic [WIDTH-1:0] rem, input logic [WIDTH-1:0] quo);
      return {nr ? -rem : rem, nq ? -quo : quo};
   endfunction

   assign w_ready  = (r_state == IDLE) && !div_cancel;
   assign w_accept = w_ready && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
   assign s_axis_dividend_tready = w_ready;
   assign s_axis_divisor_tready  = w_ready;
   assign w_sa = div_signed & s_axis_dividend_tdata[WIDTH-1];
   assign w_sb = div_signed & s_axis_divisor_tdata[WIDTH-1];
   assign w_ma = w_sa ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
   assign w_mb = w_sb ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
   // the shifted remainder can carry into bit WIDTH, so the trial subtract is WIDTH+1 wide
   assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
   assign w_rem   = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
   assign w_quo   = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= IDLE;
         r_cnt              <= '0;
         r_rem              <= '0;
         r_quo              <= '0;
         r_dvs              <= '0;
         r_nq               <= 1'b0;
         r_nr               <= 1'b0;
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tdata  <= '0;
      end else begin
         m_axis_dout_tvalid <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_rem   <= '0;
               r_quo   <= w_ma;
               r_dvs   <= w_mb;
               r_nq    <= w_sa ^ w_sb;
               r_nr    <= w_sa;
               r_cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
               if (w_mb == '0 || w_ma < w_mb) begin
                  r_state            <= DONE;
                  m_axis_dout_tvalid <= 1'b1;
                  m_axis_dout_tdata  <= fixup(w_sa ^ w_sb, w_sa, w_ma, {WIDTH{w_mb == '0}});
               end else begin
                  r_state <= BUSY;
               end
`else
               r_state <= BUSY;
`endif
            end
            BUSY: if (div_cancel) begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end else begin
               r_rem <= w_rem;
               r_quo <= w_quo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state            <= DONE;
                  m_axis_dout_tvalid <= 1'b1;
                  m_axis_dout_tdata  <= fixup(r_nq, r_nr, w_rem, w_quo);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 integer divider and the responder for the execute stage's divider handshake. It accepts a dividend/divisor pair on two valid/ready slave channels and performs one quotient bit per cycle. It returns {remainder, quotient} on a single-cycle valid master channel. One instance serves both signed and unsigned divides (div.w, mod.w, div.wu, mod.wu), with signedness selected per operation.

## Interface
- WIDTH, 32, operand width; the result is 2*WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- div_signed  in  1  signedness of the operation; sampled on the accept cycle only.
- div_cancel  in  1  pipeline flush; aborts the current operation.
- s_axis_dividend_tvalid  in  1  dividend present.
- s_axis_dividend_tready  out  1  block can accept the dividend.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_divisor_tvalid  in  1  divisor present.
- s_axis_divisor_tready  out  1  block can accept the divisor.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- m_axis_dout_tvalid  out  1  result valid; one-cycle pulse with no back-pressure.
- m_axis_dout_tdata  out  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient.

## Operation
- States:
  - IDLE: both treadys = 1 while div_cancel = 0.
  - BUSY: iteration counter runs 0..WIDTH-1.
  - DONE: result presented.
- Accept: occurs when IDLE, div_cancel = 0, and both tvalids = 1 in the same cycle.
  - On accept, latch the operands and div_signed, then go to BUSY.
  - A single tvalid alone is never accepted; the other operand is simply not consumed.
- Magnitudes:
  - Signed: |x| as an unsigned WIDTH-bit value, so |-2^(W-1)| = 2^(W-1).
  - Unsigned: the raw operand.
- Iteration (restoring):
  - Shift {rem, quo} left by one.
  - Trial = rem - |divisor| at WIDTH+1 bits.
  - If the trial is non-negative, rem = trial and the quotient LSB = 1.
- BUSY → DONE after exactly WIDTH iterations. DONE → IDLE unconditionally after one cycle.
- Sign fix-up, applied when registering the result:
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
- Divide by zero (defined result):
  - Unsigned: q = all ones, r = dividend.
  - Signed: q = 1 if the dividend is negative, else all ones; r = dividend.
- Overflow: signed -2^(W-1) / -1 gives q = 0x80000000, r = 0 with no special casing.
- Cancel:
  - div_cancel = 1 in BUSY or DONE forces IDLE on the next edge.
  - No dout_tvalid is produced for a cancelled BUSY operation.
  - A DONE-cycle pulse already visible is not retracted.
- Cancel and valids together in IDLE: cancel wins; no accept occurs and tready reads 0.
- m_axis_dout_tdata holds its value until the next result is registered.

## Timing
- Reset values: state IDLE, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0, counter 0.
  - Both treadys = 1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards the operation; no pulse follows.
- The accept handshake is observed in cycle 0:
  - Cycles 1..WIDTH are BUSY with tready = 0.
  - Cycle WIDTH+1 is DONE: dout_tvalid = 1, tready = 0.
  - Cycle WIDTH+2 is IDLE: tready = 1.
- Latency is WIDTH+1 cycles from accept to dout_tvalid. Throughput is one operation per WIDTH+2 cycles.
- tready is a function of the state register and div_cancel only. It never depends on tvalid.
- dout_tvalid and tdata are registered outputs.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - Condition: on accept, |divisor| = 0 or |dividend| < |divisor| (unsigned magnitude compare).
  - Behaviour: skip BUSY and go straight to DONE.
  - dout_tvalid appears in cycle 1.
  - Result is bit-identical to the full iteration, including the divide-by-zero values and sign rules.
- DIV_EARLY_OUT_EN undefined: every operation takes the full WIDTH+1 cycle latency. The compare logic is absent.

## Test plan
- Unsigned 100 / 7, accepted in cycle 0 → dout_tvalid only in cycle 33 with tdata = {0x00000002, 0x0000000E}; tready is 0 in cycles 1-33 and 1 in cycle 34.
- Signed -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}; signed 7 / -2 → {0x00000001, 0xFFFFFFFD}; unsigned 0xFFFFFFF9 / 2 → {0x00000001, 0x7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}, with no hang and exact cycle-33 timing.
- Divide by zero:
  - Unsigned 5 / 0 → {0x00000005, 0xFFFFFFFF}.
  - Signed -5 / 0 → {0xFFFFFFFB, 0x00000001}.
- Cancel and reset:
  - div_cancel pulsed in BUSY cycle 10 → no dout_tvalid; tready = 1 in cycle 11.
  - Then 9 / 3 is accepted → {0, 3} exactly 33 cycles later.
  - Reset mid-BUSY behaves the same way.
- Operand handshake:
  - Only the dividend tvalid high for 5 cycles → no accept; the divisor arrives in cycle 5 → accept in cycle 5.
- Early out, with DIV_EARLY_OUT_EN: unsigned 3 / 10 → {3, 0} in cycle 1. Without the macro → the same data in cycle 33.
